// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO read path: word and buffer sizes used by
// both this reader and the FIFO, plus the reader FSM state encodings.
// No logic; constants and a small sizing helper only.
package fifo_reader_pkg;

    localparam int FIFO_WORD_SIZE_DEF = 10;
    localparam int SKID_DEPTH_DEF     = 2;

    // Reader FSM encodings, kept as plain constants so older blocks that
    // decode the state bits directly keep working.
    localparam int         STATE_W = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Pointer width for a circular buffer; a depth of 1 still needs one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// In-order output buffer between the FIFO read port and the downstream handshake.
// Latency: a pushed word is visible on data_out the cycle after the push edge.
// Backpressure: never refuses a push; the caller limits pushes with occupancy.
//
// Ports: clk, reset_L (sync, active-low), push/push_data (capture a word),
//        pop (drop the oldest word), data_out (oldest word, 0 when empty),
//        occupancy (number of stored words).
module fifo_rd_skid
    import fifo_reader_pkg::*;
#(
    parameter  int WIDTH = FIFO_WORD_SIZE_DEF,
    parameter  int DEPTH = SKID_DEPTH_DEF,
    localparam int PTR_W = ptr_w(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop against an empty buffer is ignored so occupancy cannot underflow.
    assign pop_ok = pop && (occupancy != '0);

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({push, pop_ok})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage needs no reset: data_out is forced to 0 whenever it is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign data_out = (occupancy != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_reader.sv
// Pulls words from a FIFO read port and presents them on a valid/ready stream.
// Latency: 2 cycles from a fifo_rd_en cycle to valid_out; 1 word/cycle sustained.
// Backpressure: reads stop once buffered plus in-flight words fill the buffer.
//
// Ports: clk, reset_L (sync, active-low), enable (allow new reads),
//        fifo_data_out/fifo_empty_flag/fifo_error_flag/fifo_rd_en (FIFO side),
//        data_out/valid_out/ready_in (downstream), word_count (handshakes,
//        wrapping), error_out (sticky FIFO error).
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int FIFO_WORD_SIZE = FIFO_WORD_SIZE_DEF,
    parameter int SKID_DEPTH     = SKID_DEPTH_DEF,
    parameter int COUNT_SIZE     = 16
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      enable,
    input  logic [FIFO_WORD_SIZE-1:0] fifo_data_out,
    input  logic                      fifo_empty_flag,
    input  logic                      fifo_error_flag,
    output logic                      fifo_rd_en,
    output logic [FIFO_WORD_SIZE-1:0] data_out,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic [COUNT_SIZE-1:0]     word_count,
    output logic                      error_out
);

    localparam int OCC_W = $clog2(SKID_DEPTH + 1);

    logic [STATE_W-1:0]        state;
    logic [STATE_W-1:0]        state_nxt;
    logic                      in_flight;
    logic [OCC_W-1:0]          occupancy;
    logic [FIFO_WORD_SIZE-1:0] skid_dat;
    logic                      pop;
    logic [OCC_W:0]            used;
    logic                      credit_ok;

    fifo_rd_skid #(
        .WIDTH (FIFO_WORD_SIZE),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (in_flight),
        .push_data (fifo_data_out),
        .pop       (pop),
        .data_out  (skid_dat),
        .occupancy (occupancy)
    );

    // Outputs are held quiet while reset_L is low so a reset that lands
    // mid-transfer never shows a stale word downstream.
    assign valid_out = reset_L && (occupancy != '0);
    assign data_out  = reset_L ? skid_dat : '0;
    assign pop       = valid_out && ready_in;

    // Slots committed for the next cycle. Counting a same-cycle pop as a
    // freed slot is what lets a two-entry buffer sustain one word per cycle
    // across the two-cycle read latency.
    assign used      = {1'b0, occupancy} + (OCC_W + 1)'(in_flight) - (OCC_W + 1)'(pop);
    assign credit_ok = used < (OCC_W + 1)'(SKID_DEPTH);

    assign fifo_rd_en = reset_L && (state == ST_RUN) && enable
                        && !fifo_empty_flag && credit_ok;

    // An error wins over every other transition, including leaving IDLE.
    always_comb begin
        state_nxt = state;
        if (fifo_error_flag) begin
            state_nxt = ST_HALT;
        end else begin
            case (state)
                ST_IDLE: if (enable)               state_nxt = ST_RUN;
                ST_RUN:  if (!enable && !in_flight) state_nxt = ST_IDLE;
                ST_HALT:                           state_nxt = ST_HALT;
                default:                           state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state      <= ST_IDLE;
            in_flight  <= 1'b0;
            word_count <= '0;
            error_out  <= 1'b0;
        end else begin
            state     <= state_nxt;
            // The FIFO returns data the cycle after the pop; remember it so
            // that word is captured whatever state we are in by then.
            in_flight <= fifo_rd_en;
            if (pop) begin
                word_count <= word_count + COUNT_SIZE'(1);
            end
            if (fifo_error_flag) begin
                error_out <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
- REQ-001: Parameter FIFO_WORD_SIZE, default 10, width of every data word.
- REQ-002: Parameter SKID_DEPTH, default 2, entries in the internal output buffer.
- REQ-003: Parameter COUNT_SIZE, default 16, width of the delivered-word counter.
- REQ-004: clk  input  1  the single clock; all logic is on the rising edge.
- REQ-005: reset_L  input  1  reset; synchronous, active-low.
- REQ-006: enable  input  1  permits new FIFO reads while high.
- REQ-007: fifo_data_out  input  FIFO_WORD_SIZE  read data from the FIFO, valid one cycle after fifo_rd_en.
- REQ-008: fifo_empty_flag  input  1  FIFO empty indication.
- REQ-009: fifo_error_flag  input  1  FIFO overflow/underflow indication.
- REQ-010: fifo_rd_en  output  1  pop request to the FIFO.
- REQ-011: data_out  output  FIFO_WORD_SIZE  word presented downstream.
- REQ-012: valid_out  output  1  data_out holds a valid word.
- REQ-013: ready_in  input  1  downstream accepts data_out this cycle.
- REQ-014: word_count  output  COUNT_SIZE  number of completed downstream handshakes, modulo 2^COUNT_SIZE.
- REQ-015: error_out  output  1  sticky; set by FIFO error.

Function
- REQ-016: The FSM SHALL have exactly three states: IDLE, RUN and HALT.
- REQ-017: Transitions: IDLE->RUN when enable=1; RUN->IDLE when enable=0 and no read is in flight; any state->HALT when fifo_error_flag=1; HALT is left only by reset.
- REQ-018: fifo_rd_en SHALL be 1 only if state=RUN, enable=1, fifo_empty_flag=0, and (buffer occupancy + reads in flight) < SKID_DEPTH.
- REQ-019: Every fifo_rd_en=1 cycle SHALL cause fifo_data_out to be captured into the buffer on the following rising edge, with no loss or duplication.
- REQ-020: Minimum latency SHALL be 2 cycles from the fifo_rd_en edge to valid_out=1.
- REQ-021: Under continuous ready_in=1 and a non-empty FIFO, throughput SHALL be one word per cycle.
- REQ-022: The buffer SHALL be in-order.
- REQ-023: valid_out SHALL equal (occupancy != 0).
- REQ-024: data_out SHALL be the oldest buffer entry.
- REQ-025: While valid_out=1 and ready_in=0, data_out SHALL stay stable.
- REQ-026: Push (capture) and pop (valid_out and ready_in) in the same cycle SHALL leave occupancy unchanged.
- REQ-027: word_count SHALL increment by 1 on each valid_out and ready_in cycle, and wrap from all-ones to 0.
- REQ-028: In IDLE, buffered words SHALL still drain downstream; only new reads stop.
- REQ-029: In HALT: no reads; an in-flight read is still captured; buffered words still drain; error_out=1.
- REQ-030: If fifo_error_flag=1 in the same cycle as enable rising, the FSM SHALL enter HALT, not RUN.

Reset
- REQ-031: On a rising clk edge with reset_L=0, the block SHALL set state=IDLE, empty the buffer, clear the in-flight flag, and set word_count=0 and error_out=0.
- REQ-032: During and immediately after reset, the block SHALL drive fifo_rd_en=0 and valid_out=0; data_out SHALL be 0.
- REQ-033: A reset asserted mid-transfer SHALL discard buffered and in-flight words without asserting valid_out.

Structure
- REQ-034: FIFO_WORD_SIZE default, SKID_DEPTH default and the FSM state encodings SHALL reside in a shared transaction-layer include file used by this block and the FIFO.
- REQ-035: The buffer SHALL be one sub-module, fifo_rd_skid (push, pop, occupancy, data_out); the FSM and counter SHALL live in fifo_reader.
- REQ-036: RTL SHALL be synthesizable with the team's cmos_cells flow.
- REQ-037: The gate-level netlist SHALL match the behavioural model cycle-for-cycle.

Verification
- REQ-038: Bench SHALL cover basic stream: FIFO preloaded with 0x001..0x005, enable=1, ready_in=1 -> data_out 0x001..0x005 on consecutive cycles, first valid 2 cycles after first fifo_rd_en, word_count=5.
- REQ-039: Bench SHALL cover backpressure: ready_in=0 for 6 cycles with a full FIFO -> exactly SKID_DEPTH=2 reads issued, data_out held at the first word; after release, order preserved with no gaps.
- REQ-040: Bench SHALL cover empty boundary: single word 0x3FF written into an idle FIFO -> exactly one fifo_rd_en pulse, one valid_out cycle, and fifo_rd_en never asserted while fifo_empty_flag=1.
- REQ-041: Bench SHALL cover disable mid-stream: enable dropped after 3 reads -> in-flight word still delivered, no further fifo_rd_en, state returns to IDLE.
- REQ-042: Bench SHALL cover the error path: fifo_error_flag pulsed 1 cycle -> HALT, error_out=1 sticky, buffered words drained, no reads until reset_L=0, then all outputs at 0.
- REQ-043: Bench SHALL cover counter wrap: with COUNT_SIZE=4, 17 words delivered -> word_count=1.
